alu_issue_unit: RTL

- Register-file-backed issue stage that sits directly upstream of the 32-bit yAlu and also consumes its result.
- Accepts one ALU command at a time over a valid/ready handshake, reads two source registers and drives yAlu's a, b and op.
- Samples yAlu's z and ex, then writes z back to the destination register.
- yAlu itself is instantiated outside this block and wired to the alu_* ports.

---
 rtl/alu_issue_unit_if.sv | 43 ++++
 rtl/alu_issue_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_issue_unit_if.sv
// Command / load / yAlu / completion / debug bus of alu_issue_unit.
// slave modport is the issue unit side; master is the side that drives
// commands and hosts yAlu.
interface alu_issue_unit_if #(
  parameter int W  = 32,
  parameter int AW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs;
  logic [AW-1:0] cmd_rt;
  logic [AW-1:0] cmd_rd;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_z;
  logic          alu_ex;
  logic          done;
  logic [W-1:0]  done_data;
  logic          done_err;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd,
    input  ld_en, ld_addr, ld_data,
    input  alu_z, alu_ex, dbg_addr,
    output cmd_ready, alu_a, alu_b, alu_op,
    output done, done_data, done_err, dbg_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd,
    output ld_en, ld_addr, ld_data,
    output alu_z, alu_ex, dbg_addr,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  done, done_data, done_err, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: register-file-backed issue stage for an external 32-bit
// yAlu. One command at a time: IDLE -> READ -> EXEC -> WB -> IDLE.
// Optional macro ALU_STATUS_EN adds status_zero / status_count outputs.
module alu_issue_unit #(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_unit_if.slave bus
`ifdef ALU_STATUS_EN
  ,
  output logic            status_zero,
  output logic [15:0]     status_count
`endif
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  state_e                   state_q;
  logic                     ready_q;
  logic [2:0]               op_q;
  logic [AW-1:0]            rs_q, rt_q, rd_q;
  logic [W-1:0]             a_q, b_q;
  logic [2:0]               aop_q;
  logic [W-1:0]             z_q;
  logic                     ex_q;
  logic                     done_q, err_q;
  logic [W-1:0]             done_data_q;
  logic [NREG-1:0][W-1:0]   rf_q;

  // ops yAlu implements; anything else completes with an error and no write
  function automatic logic op_legal(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // Register 0 is never written, so it always reads as zero.
  function automatic logic [W-1:0] rf_rd(input logic [NREG-1:0][W-1:0] rf,
                                         input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : rf[addr];
  endfunction

  // FSM, operand/result registers and register file; WB write placed after
  // the load so it wins a same-register collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aop_q       <= '0;
      z_q         <= '0;
      ex_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_data_q <= '0;
      rf_q        <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.ld_en && bus.ld_addr != '0) rf_q[bus.ld_addr] <= bus.ld_data;
      unique case (state_q)
        IDLE: begin
          if (ready_q && bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            rs_q    <= bus.cmd_rs;
            rt_q    <= bus.cmd_rt;
            rd_q    <= bus.cmd_rd;
            ready_q <= 1'b0;
            state_q <= READ;
          end else begin
            ready_q <= 1'b1;
          end
        end
        READ: begin
          a_q     <= rf_rd(rf_q, rs_q);
          b_q     <= rf_rd(rf_q, rt_q);
          aop_q   <= op_q;
          state_q <= EXEC;
        end
        EXEC: begin
          z_q     <= bus.alu_z;
          ex_q    <= bus.alu_ex;
          state_q <= WB;
        end
        WB: begin
          done_q <= 1'b1;
          if (op_legal(op_q)) begin
            done_data_q <= z_q;
            if (rd_q != '0) rf_q[rd_q] <= z_q;
          end else begin
            done_data_q <= '0;
            err_q       <= 1'b1;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = aop_q;
  assign bus.done      = done_q;
  assign bus.done_data = done_data_q;
  assign bus.done_err  = err_q;
  assign bus.dbg_data  = rf_rd(rf_q, bus.dbg_addr);

`ifdef ALU_STATUS_EN
  logic        sz_q;
  logic [15:0] cnt_q;

  // zero flag and completion count track only successful write-backs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == WB && op_legal(op_q)) begin
      sz_q  <= ex_q;
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign status_zero  = sz_q;
  assign status_count = cnt_q;
`else
  logic unused_ex;
  assign unused_ex = ex_q;
`endif
endmodule
